// File: rtl/mcu_pkg.sv
// -----------------------------------------------------------------------------
// mcu_pkg
// Shared definitions for the MCU controller and the ALU/accumulator datapath.
// Holds the 4-bit ALU opcode encodings, the bit positions of the status flags
// inside the 4-bit flag vector {DZ, V, C, Z}, and the default operand width.
// -----------------------------------------------------------------------------
package mcu_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // ALU opcodes. Encodings above ALU_SHR are reserved and behave as ALU_NOP.
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_NOT = 4'b0111;
    localparam logic [3:0] ALU_SHL = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1001;

    // Flag bit indices within the flags vector.
    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 2;
    localparam int FLAG_DZ = 3;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU. Maps an opcode and two unsigned operands to a
// double-width result, the {DZ, V, C, Z} flags, and a hold indication for
// opcodes that must leave the accumulator and flags untouched.
//
// Ports:
//   i_op      opcode (mcu_pkg ALU_*)
//   i_a       operand A, W bits
//   i_b       operand B, W bits (shift amount for shifts)
//   o_result  2*W-bit result
//   o_flags   {DZ, V, C, Z} for this result
//   o_hold    1 = opcode is a no-op; result/flags must not be written
// -----------------------------------------------------------------------------
module alu_core
    import mcu_pkg::*;
#(
    parameter int W   = WIDTH_DEFAULT,
    parameter int SHW = 5
) (
    input  logic [3:0]     i_op,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_result,
    output logic [3:0]     o_flags,
    output logic           o_hold
);

    localparam logic [W-1:0] C_W  = W'(W);
    localparam logic [W-1:0] C_2W = W'(2 * W);

    logic [W:0]     w_sum;
    logic [W-1:0]   w_diff;
    logic           w_borrow;
    logic [2*W-1:0] w_prod;
    logic           w_bz;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [3*W-1:0] w_shl_x;
    logic [W:0]     w_shr_x;
    logic [2*W-1:0] w_res;
    logic           w_c;
    logic           w_v;
    logic           w_dz;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff   = i_a - i_b;
    assign w_borrow = (i_a < i_b);
    assign w_prod   = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    assign w_bz     = (i_b == '0);
    assign w_quot   = w_bz ? '1  : i_a / i_b;
    assign w_rem    = w_bz ? i_a : i_a % i_b;

    // Left shift is done in a 3*W-wide field so the bits pushed past the top
    // of the 2*W result are still visible for the carry.
    assign w_shl_x  = {{(2 * W){1'b0}}, i_a} << i_b[SHW-1:0];

    // Right shift keeps one guard bit below the LSB: after the shift, bit 0
    // is the last bit shifted out and bits [W:1] are the shifted operand.
    assign w_shr_x  = {i_a, 1'b0} >> i_b[SHW-1:0];

    always_comb begin
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_dz   = 1'b0;
        o_hold = 1'b0;
        case (i_op)
            ALU_ADD: begin
                w_res = {{(W-1){1'b0}}, w_sum};
                w_c   = w_sum[W];
                w_v   = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
            end
            ALU_SUB: begin
                w_res = {{W{w_borrow}}, w_diff};
                w_c   = w_borrow;
                w_v   = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
            end
            ALU_MUL: w_res = w_prod;
            ALU_DIV: begin
                w_res = {w_rem, w_quot};
                w_dz  = w_bz;
            end
            ALU_AND: w_res = {{W{1'b0}}, i_a & i_b};
            ALU_OR:  w_res = {{W{1'b0}}, i_a | i_b};
            ALU_NOT: w_res = {{W{1'b0}}, ~i_a};
            ALU_SHL: begin
                if (i_b < C_2W) begin
                    w_res = w_shl_x[2*W-1:0];
                    w_c   = |w_shl_x[3*W-1:2*W];
                end else begin
                    // Every bit of the operand has left the result.
                    w_c   = |i_a;
                end
            end
            ALU_SHR: begin
                if (i_b < C_W) begin
                    w_res = {{W{1'b0}}, w_shr_x[W:1]};
                end
                // Beyond W the last bit out is a zero from the upper half.
                w_c = (i_b <= C_W) ? w_shr_x[0] : 1'b0;
            end
            default: o_hold = 1'b1;
        endcase

        o_result          = w_res;
        o_flags           = '0;
        o_flags[FLAG_Z]   = (w_res == '0);
        o_flags[FLAG_C]   = w_c;
        o_flags[FLAG_V]   = w_v;
        o_flags[FLAG_DZ]  = w_dz;
    end

endmodule

// File: rtl/alu_acc.sv
// -----------------------------------------------------------------------------
// alu_acc
// Two-stage pipelined ALU/accumulator downstream of the MCU controller.
// Stage 1 registers the opcode and operands every edge; stage 2 registers the
// alu_core result into dataACC/flags unless the opcode is a hold opcode.
// Input-to-dataACC latency is two edges with a new operation accepted every
// cycle.
//
// resultValid: high when dataACC/flags were produced from the inputs
// currently presented, i.e. the inputs matched the stage-1 registers on this
// edge and at least one capture has happened since reset.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   functionSelect  opcode (mcu_pkg ALU_*)
//   arin, brin      operands A and B, WIDTH bits
//   dataACC         registered 2*WIDTH result
//   resultValid     dataACC/flags correspond to the current inputs
//   flags           registered {DZ, V, C, Z}
// -----------------------------------------------------------------------------
module alu_acc
    import mcu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SHW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         functionSelect,
    input  logic [WIDTH-1:0]   arin,
    input  logic [WIDTH-1:0]   brin,
    output logic [2*WIDTH-1:0] dataACC,
    output logic               resultValid,
    output logic [3:0]         flags
);

    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [3:0]         r_flags;
    logic               r_valid;
    logic               r_primed;

    logic [2*WIDTH-1:0] w_result;
    logic [3:0]         w_flags;
    logic               w_hold;
    logic               w_changed;

    alu_core #(
        .W   (WIDTH),
        .SHW (SHW)
    ) u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_flags  (w_flags),
        .o_hold   (w_hold)
    );

    assign w_changed = (functionSelect != r_op) || (arin != r_a) || (brin != r_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_op     <= functionSelect;
            r_a      <= arin;
            r_b      <= brin;
            r_primed <= 1'b1;
            // Stage 2 computes from the stage-1 registers; if the inputs equal
            // them, the result landing now belongs to the current inputs.
            r_valid  <= r_primed && !w_changed;
            if (!w_hold) begin
                r_acc   <= w_result;
                r_flags <= w_flags;
            end
        end
    end

    assign dataACC     = r_acc;
    assign flags       = r_flags;
    assign resultValid = r_valid;

endmodule

// File: tb/tb_alu_acc.sv
// -----------------------------------------------------------------------------
// tb_alu_acc
// Self-checking bench for alu_acc. Each driven cycle pushes the expected
// {flags, dataACC} of a reference model into exp_q; the entry is popped and
// compared when the result emerges two edges later. resultValid is checked
// every cycle against the input history.
// -----------------------------------------------------------------------------
module tb_alu_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fs;
    logic [15:0] arin;
    logic [15:0] brin;
    logic [31:0] dataACC;
    logic        resultValid;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    logic [35:0] exp_q[$];
    logic [31:0] m_acc;
    logic [3:0]  m_flags;
    logic [35:0] prev_in;
    int          edges;

    always #5 clk = ~clk;

    alu_acc #(
        .WIDTH (16),
        .SHW   (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .functionSelect (fs),
        .arin           (arin),
        .brin           (brin),
        .dataACC        (dataACC),
        .resultValid    (resultValid),
        .flags          (flags)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_acc/m_flags the way the accumulator should.
    task automatic model_step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        logic [16:0] s;
        logic [15:0] d;
        logic [15:0] t;
        logic [63:0] w;
        logic        c, v, dz;
        if (op == 4'd0 || op > 4'd9) return;
        r = 0; c = 0; v = 0; dz = 0;
        case (op)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                r = {15'b0, s};
                c = s[16];
                v = (a[15] == b[15]) && (s[15] != a[15]);
            end
            4'd2: begin
                d = a - b;
                r = {(a < b) ? 16'hFFFF : 16'h0000, d};
                c = (a < b);
                v = (a[15] != b[15]) && (d[15] != a[15]);
            end
            4'd3: r = {16'b0, a} * {16'b0, b};
            4'd4: begin
                if (b == 0) begin
                    r  = {a, 16'hFFFF};
                    dz = 1;
                end else begin
                    r = {a % b, a / b};
                end
            end
            4'd5: r = {16'b0, a & b};
            4'd6: r = {16'b0, a | b};
            4'd7: r = {16'b0, ~a};
            4'd8: begin
                if (b < 32) begin
                    w = {48'b0, a} << b;
                    r = w[31:0];
                    c = (w[63:32] != 0);
                end else begin
                    c = (a != 0);
                end
            end
            default: begin
                if (b < 16) r = {16'b0, a} >> b;
                if (b >= 1 && b <= 16) begin
                    t = a >> (b - 16'd1);
                    c = t[0];
                end
            end
        endcase
        m_acc   = r;
        m_flags = {dz, v, c, (r == 0)};
    endtask

    // One clock cycle of stimulus plus the checks that fall due at its edge.
    task automatic cycle(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [35:0] cur;
        logic [35:0] exp;
        logic        exp_v;
        fs   = op;
        arin = a;
        brin = b;
        model_step(op, a, b);
        exp_q.push_back({m_flags, m_acc});
        cur   = {op, a, b};
        exp_v = (edges >= 1) && (cur == prev_in);
        @(posedge clk);
        #1;
        edges++;
        prev_in = cur;
        check($sformatf("valid op=%0d", op), {35'b0, resultValid}, {35'b0, exp_v});
        if (exp_q.size() == 2) begin
            exp = exp_q.pop_front();
            check("acc_flags", {flags, dataACC}, exp);
        end
    endtask

    task automatic cycle2(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        cycle(op, a, b);
        cycle(op, a, b);
    endtask

    task automatic check_out(input string tag, input logic [31:0] acc, input logic [3:0] fl);
        check(tag, {flags, dataACC}, {fl, acc});
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc   = 0;
        m_flags = 0;
        prev_in = 0;
        edges   = 0;
    endtask

    initial begin
        // Reset held with add 5+3 on the inputs.
        rst  = 1'b0;
        fs   = 4'd1;
        arin = 16'd5;
        brin = 16'd3;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {resultValid, flags, dataACC}, 36'h0);
        rst = 1'b1;
        cycle2(4'd1, 16'd5, 16'd3);
        check_out("reset_release_add", 32'h0000_0008, 4'h0);
        check("reset_release_valid", {35'b0, resultValid}, 36'h1);

        cycle2(4'd1, 16'hFFFF, 16'h0001);
        check_out("add_carry", 32'h0001_0000, 4'h2);
        cycle2(4'd2, 16'h0003, 16'h0005);
        check_out("sub_borrow", 32'hFFFF_FFFE, 4'h2);
        cycle2(4'd1, 16'h7FFF, 16'h0001);
        check_out("add_overflow", 32'h0000_8000, 4'h4);
        cycle2(4'd2, 16'h8000, 16'h0001);
        check_out("sub_overflow", 32'h0000_7FFF, 4'h4);

        cycle2(4'd3, 16'hFFFF, 16'hFFFF);
        check_out("mul", 32'hFFFE_0001, 4'h0);
        cycle2(4'd4, 16'd100, 16'd7);
        check_out("div", 32'h0002_000E, 4'h0);
        cycle2(4'd4, 16'd100, 16'd0);
        check_out("div_zero", 32'h0064_FFFF, 4'h8);

        cycle2(4'd8, 16'h8001, 16'd17);
        check_out("shl17", 32'h0002_0000, 4'h2);
        cycle2(4'd9, 16'h8001, 16'd1);
        check_out("shr1", 32'h0000_4000, 4'h2);
        cycle2(4'd8, 16'h8001, 16'd40);
        check("shl40", {31'b0, flags[0], dataACC}, {31'b0, 1'b1, 32'h0});
        cycle2(4'd7, 16'h00FF, 16'h1234);
        check_out("not", 32'h0000_FF00, 4'h0);

        // Hold opcodes leave accumulator and flags alone.
        cycle2(4'd5, 16'h0F0F, 16'h00FF);
        check_out("and", 32'h0000_000F, 4'h0);
        cycle2(4'd0, 16'h1234, 16'h5678);
        check_out("hold_nop", 32'h0000_000F, 4'h0);
        cycle2(4'd12, 16'hAAAA, 16'h5555);
        check_out("hold_1100", 32'h0000_000F, 4'h0);

        // Back-to-back opcodes, then a stable stretch.
        cycle(4'd1, 16'd1, 16'd2);
        cycle(4'd2, 16'd10, 16'd3);
        cycle(4'd6, 16'h00F0, 16'h000F);
        cycle2(4'd6, 16'h00F0, 16'h000F);
        check_out("or_stream", 32'h0000_00FF, 4'h0);

        // Random mix including reserved opcodes and out-of-range shifts.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            int          reps;
            op   = 4'($urandom_range(0, 15));
            a    = 16'($urandom_range(0, 65535));
            b    = (op >= 4'd8) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 65535));
            reps = $urandom_range(1, 3);
            for (int k = 0; k < reps; k++) cycle(op, a, b);
        end

        // Asynchronous reset in the middle of a stream.
        cycle(4'd1, 16'h1111, 16'h2222);
        cycle(4'd3, 16'h0100, 16'h0100);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_out", {resultValid, flags, dataACC}, 36'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold_out", {resultValid, flags, dataACC}, 36'h0);
        rst = 1'b1;
        cycle2(4'd6, 16'h00F0, 16'h0F00);
        check_out("post_reset_or", 32'h0000_0FF0, 4'h0);
        check("post_reset_valid", {35'b0, resultValid}, 36'h1);
        cycle2(4'd2, 16'h0005, 16'h0005);
        check_out("sub_zero", 32'h0000_0000, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_acc.md
Name: alu_acc

Overview:
- Two-stage pipelined arithmetic/logic unit that sits directly downstream of the MCU controller.
- Each cycle it consumes functionSelect, arin and brin, and produces the 32-bit accumulator result dataACC, which the controller latches into arin (low half) and hacc (high half).
- The controller samples dataACC three cycles after it drives functionSelect. The 2-cycle latency of this block fits inside that window.
- Also provides status flags and a result-valid indication for the bench and future branch-on-flag instructions.

Parameters:
- WIDTH, 16, operand width; result width is 2*WIDTH.
- SHW, 5, number of brin LSBs used as shift amount (log2 of 2*WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- functionSelect  input  4  opcode from controller.
- arin  input  WIDTH  operand A.
- brin  input  WIDTH  operand B.
- dataACC  output  2*WIDTH  registered result.
- resultValid  output  1  dataACC/flags correspond to the current inputs.
- flags  output  4  {DZ, V, C, Z}, registered with dataACC.

Behaviour:
- Reset (rst=0, asynchronous): stage-1 registers (op, a, b) cleared to 0; dataACC=0; flags=0; resultValid=0. Reset mid-operation discards any in-flight result. The first capture happens on the first rising edge after rst returns to 1.
- Stage 1, every edge: op_q<=functionSelect, a_q<=arin, b_q<=brin.
- Stage 2, every edge: computes from op_q/a_q/b_q; dataACC/flags update per the opcode table below.
- Latency is 2 edges from input change to dataACC.
- resultValid:
  - low on the edge after any input differs from stage-1 registers;
  - high once inputs have been stable for 2 consecutive edges;
  - stays high while inputs remain stable.
- Opcodes (upper half written exactly as stated):
  - 0000 no-op: dataACC and flags hold.
  - 0001 add: {15'b0, carry, a+b}. C=carry; V=signed overflow.
  - 0010 sub: low=a-b; high=16'hFFFF if a<b unsigned, else 0. C=borrow (a<b); V=signed overflow.
  - 0011 mul: unsigned full 32-bit product. C=V=0.
  - 0100 div: low=a/b, high=a%b unsigned. If b==0: low=16'hFFFF, high=a, DZ=1, otherwise DZ=0.
  - 0101 and: {16'b0, a&b}.
  - 0110 or: {16'b0, a|b}.
  - 0111 not: {16'b0, ~a}. brin ignored.
  - 1000 shl: {16'b0,a} << b[SHW-1:0] if b<32, else 0. C = OR of bits shifted past bit 31.
  - 1001 shr: logical {16'b0,a} >> b if b<16, else 0. C = last bit shifted out (0 if b==0).
  - 1010..1111: treated exactly as no-op (hold).
- Flag rules:
  - Z = (new dataACC == 0), for every non-hold opcode.
  - C, V, DZ are cleared by any non-hold opcode that does not define them.
  - Hold opcodes keep all flags.
- Simultaneous events:
  - An input change on the same edge a result lands: the new result registers and resultValid drops on that edge.
  - Back-to-back opcodes each produce a result 2 edges later, with no bubbles.
- Width rules: all arithmetic is unsigned unless stated; no sign extension of operands.

Decomposition:
- Shared package mcu_pkg holds:
  - opcode constants ALU_NOP..ALU_SHR (4-bit);
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_DZ=3;
  - WIDTH default.
  The controller is to adopt the same constants.
- One sub-module, alu_core: purely combinational; maps op/a/b to result/flags/hold. alu_acc owns only the pipeline registers, hold mux and resultValid logic.

Test Plan:
- Reset: hold rst=0 with inputs driven to add 5+3. Expect dataACC=0, flags=0, resultValid=0. Release rst; after 2 edges expect dataACC=0x00000008, resultValid=1.
- Add carry: a=0xFFFF, b=0x0001, op=0001 → dataACC=0x00010000, C=1, Z=0 on edge 2. Then sub a=0x0003, b=0x0005 → 0xFFFFFFFE, C=1.
- Mul/div: a=0xFFFF, b=0xFFFF, mul → 0xFFFE0001. Then div a=100, b=7 → 0x0002000E. Then div b=0 → 0x0064FFFF, DZ=1.
- Shifts: a=0x8001 shl b=17 → 0x00020000, C=1. Then shr b=1 → 0x00004000, C=1. Then shl b=40 → 0, Z=1.
- Hold: after and 0x0F0F&0x00FF (→0x0000000F), apply op=0000 and op=1100 with new operands. dataACC stays 0x0000000F, flags unchanged.
- Pipeline/valid: change op every cycle (add, sub, or). Results appear in order 2 edges later; resultValid low until inputs are stable for 2 edges. Assert rst low mid-stream: outputs clear immediately, without waiting for a clock edge.
